// File: rtl/sha256_msg_feeder.sv
// SHA-256 message front end: pads a byte stream into 512-bit blocks and sequences
// the compression core one block at a time, returning the final digest.
module sha256_msg_feeder (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_keep,
  input  logic         in_last,
  output logic [511:0] blk_data,
  output logic         blk_start,
  output logic         blk_first,
  input  logic         core_ready,
  input  logic [255:0] core_hash,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_REL   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [511:0]   blk_q, blk_d;
  logic [6:0]     pos_q, pos_d;
  logic [63:0]    len_q, len_d;
  logic           first_q, first_d;
  logic           pend_len_q, pend_len_d;
  logic           pad80_q, pad80_d;
  logic           fin_q, fin_d;
  logic [255:0]   digest_q, digest_d;
  logic           dvalid_q, dvalid_d;

  logic [6:0]     pos_n;
  logic [63:0]    len_n;

  // Bit offset of byte p inside the block; byte 0 occupies the top byte.
  function automatic logic [8:0] byte_off(input logic [6:0] p);
    return 9'd504 - {p[5:0], 3'b000};
  endfunction

  // Next-state, block assembly and digest capture.
  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    pos_d      = pos_q;
    len_d      = len_q;
    first_d    = first_q;
    pend_len_d = pend_len_q;
    pad80_d    = pad80_q;
    fin_d      = fin_q;
    digest_d   = digest_q;
    dvalid_d   = 1'b0;
    pos_n      = pos_q;
    len_n      = len_q;

    case (state_q)
      S_FILL: begin
        if (in_valid) begin
          if (in_keep) begin
            blk_d[byte_off(pos_q) +: 8] = in_data;
            pos_n = pos_q + 7'd1;
            len_n = len_q + 64'd8;
          end else begin
            pos_n = pos_q;
            len_n = len_q;
          end
          pos_d = pos_n;
          len_d = len_n;
          if (in_last) begin
            // Terminator and length go where they fit; otherwise a trailing block is owed.
            if (pos_n <= 7'd55) begin
              blk_d[byte_off(pos_n) +: 8] = 8'h80;
              blk_d[63:0]                 = len_n;
              fin_d                       = 1'b1;
            end else if (pos_n <= 7'd63) begin
              blk_d[byte_off(pos_n) +: 8] = 8'h80;
              pend_len_d                  = 1'b1;
              fin_d                       = 1'b0;
            end else begin
              pend_len_d = 1'b1;
              pad80_d    = 1'b1;
              fin_d      = 1'b0;
            end
            state_d = S_ISSUE;
          end else if (pos_n == 7'd64) begin
            fin_d   = 1'b0;
            state_d = S_ISSUE;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = S_FILL;
        end
      end

      S_ISSUE: begin
        // Core drops ready on the edge it samples start.
        if (!core_ready) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_ISSUE;
        end
      end

      S_WAIT: begin
        if (core_ready) begin
          if (fin_q) begin
            digest_d = core_hash;
            dvalid_d = 1'b1;
          end else begin
            dvalid_d = 1'b0;
          end
          state_d = S_REL;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_REL: begin
        blk_d   = 512'd0;
        pos_d   = 7'd0;
        first_d = fin_q;
        if (pend_len_q) begin
          if (pad80_q) begin
            blk_d[511:504] = 8'h80;
          end else begin
            blk_d[511:504] = 8'h00;
          end
          blk_d[63:0] = len_q;
          pend_len_d  = 1'b0;
          pad80_d     = 1'b0;
          fin_d       = 1'b1;
          state_d     = S_ISSUE;
        end else begin
          if (fin_q) begin
            len_d = 64'd0;
          end else begin
            len_d = len_q;
          end
          state_d = S_FILL;
        end
      end

      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FILL;
      blk_q      <= 512'd0;
      pos_q      <= 7'd0;
      len_q      <= 64'd0;
      first_q    <= 1'b1;
      pend_len_q <= 1'b0;
      pad80_q    <= 1'b0;
      fin_q      <= 1'b0;
      digest_q   <= 256'd0;
      dvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      pos_q      <= pos_d;
      len_q      <= len_d;
      first_q    <= first_d;
      pend_len_q <= pend_len_d;
      pad80_q    <= pad80_d;
      fin_q      <= fin_d;
      digest_q   <= digest_d;
      dvalid_q   <= dvalid_d;
    end
  end

  assign in_ready     = (state_q == S_FILL) && !rst;
  assign blk_start    = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign blk_data     = blk_q;
  assign blk_first    = first_q;
  assign digest       = digest_q;
  assign digest_valid = dvalid_q;
  assign busy         = !((state_q == S_FILL) && (len_q == 64'd0) && !pend_len_q);

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Bench for sha256_msg_feeder: behavioural SHA-256 core plus table-driven messages
// and hand-written sequences for throttling, back-to-back, protocol error and reset.
module tb_sha256_msg_feeder;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_keep, in_last;
  logic [7:0]   in_data;
  logic [511:0] blk_data;
  logic         blk_start, blk_first, core_ready;
  logic [255:0] core_hash, digest;
  logic         digest_valid, busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sha256_msg_feeder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_keep(in_keep), .in_last(in_last), .blk_data(blk_data), .blk_start(blk_start),
    .blk_first(blk_first), .core_ready(core_ready), .core_hash(core_hash),
    .digest(digest), .digest_valid(digest_valid), .busy(busy)
  );

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_56    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_comp(input logic [255:0] hin, input logic [511:0] b);
    logic [31:0] w [64];
    logic [31:0] a, bb, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, bb, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
      s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
      t2 = s0 + ((a & bb) ^ (a & c) ^ (bb & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = bb; bb = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + bb, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // Independent padding + hashing of a whole message.
  function automatic logic [255:0] sha_ref(input string s);
    logic [7:0]   q[$];
    logic [63:0]  bl;
    logic [255:0] h;
    logic [511:0] blk;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    q.push_back(8'h80);
    while (q.size() % 64 != 56) q.push_back(8'h00);
    bl = 64'(s.len()) * 64'd8;
    for (int i = 0; i < 8; i++) q.push_back(bl[63 - 8*i -: 8]);
    h = IV;
    for (int bi = 0; bi < q.size() / 64; bi++) begin
      for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = q[bi*64 + j];
      h = sha_comp(h, blk);
    end
    return h;
  endfunction

  // Behavioural core: idle(ready) -> busy 64 cycles -> done(ready) until start drops.
  int           cst, ccnt, nblk;
  logic [511:0] cap_blk [64];
  logic         cap_first [64];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cst <= 0; ccnt <= 0; nblk <= 0; core_ready <= 1'b1; core_hash <= 256'd0;
    end else begin
      case (cst)
        0: if (blk_start) begin
          cap_blk[nblk % 64]   <= blk_data;
          cap_first[nblk % 64] <= blk_first;
          nblk      <= nblk + 1;
          core_hash <= sha_comp(blk_first ? IV : core_hash, blk_data);
          core_ready <= 1'b0;
          ccnt <= 0;
          cst  <= 1;
        end
        1: begin
          ccnt <= ccnt + 1;
          if (ccnt == 63) begin core_ready <= 1'b1; cst <= 2; end
        end
        default: if (!blk_start) cst <= 0;
      endcase
    end
  end

  // in_ready must stay low while a block is out at the core or being released.
  int viol = 0;
  always @(negedge clk) begin
    if (!rst && ((blk_start && in_ready) || (digest_valid && in_ready))) viol <= viol + 1;
  end

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic k, input logic l, input int gap);
    int w;
    @(negedge clk);
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
    w = 0;
    while (!in_ready && w < 1000) begin @(negedge clk); w++; end
    if (!in_ready) check("handshake_timeout", 512'(in_ready), 512'd1);
  endtask

  task automatic send_msg(input string s, input bit empty, input int gapmax);
    if (empty) send_beat(8'h00, 1'b0, 1'b1, 0);
    else for (int i = 0; i < s.len(); i++)
      send_beat(s[i], 1'b1, i == s.len() - 1, (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
  endtask

  task automatic wait_digest(output bit ok);
    int w;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; in_keep = 1'b0;
    w = 0;
    while (!digest_valid && w < 2000) begin @(negedge clk); w++; end
    ok = digest_valid;
  endtask

  typedef struct {
    string        msg;
    bit           empty;
    int           gap;
    int           nblk;
    logic [255:0] exp;
  } vec_t;

  vec_t  vt [8];
  string s56, s64;
  int    base;
  bit    ok;

  initial begin
    s56 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    s64 = "0123456789abcdef0123456789abcdef0123456789abcdef0123456789abcdef";
    vt[0] = '{"abc",               1'b0, 0, 1, D_ABC};
    vt[1] = '{"",                  1'b1, 0, 1, D_EMPTY};
    vt[2] = '{s56,                 1'b0, 0, 2, D_56};
    vt[3] = '{s64,                 1'b0, 0, 2, sha_ref(s64)};
    vt[4] = '{s56.substr(0, 54),   1'b0, 0, 1, sha_ref(s56.substr(0, 54))};
    vt[5] = '{s64.substr(0, 62),   1'b0, 0, 2, sha_ref(s64.substr(0, 62))};
    vt[6] = '{"abc",               1'b0, 3, 1, D_ABC};
    vt[7] = '{s56,                 1'b0, 2, 2, D_56};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_keep = 1'b0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 512'(in_ready), 512'd0);
    check("rst_blk_data", blk_data, 512'd0);
    check("rst_blk_start", 512'(blk_start), 512'd0);
    check("rst_blk_first", 512'(blk_first), 512'd1);
    check("rst_digest", 512'(digest), 512'd0);
    check("rst_digest_valid", 512'(digest_valid), 512'd0);
    check("rst_busy", 512'(busy), 512'd0);
    rst = 1'b0;
    #1 check("post_rst_in_ready", 512'(in_ready), 512'd1);

    for (int i = 0; i < 8; i++) begin
      base = nblk;
      send_msg(vt[i].msg, vt[i].empty, vt[i].gap);
      wait_digest(ok);
      check($sformatf("v%0d_dvalid", i), 512'(ok), 512'd1);
      check($sformatf("v%0d_digest", i), 512'(digest), 512'(vt[i].exp));
      check($sformatf("v%0d_nblk", i), 512'(nblk - base), 512'(vt[i].nblk));
      check($sformatf("v%0d_first0", i), 512'(cap_first[base % 64]), 512'd1);
      if (vt[i].nblk == 2) check($sformatf("v%0d_first1", i), 512'(cap_first[(base + 1) % 64]), 512'd0);
      case (i)
        0: check("abc_block", cap_blk[base % 64], {32'h61626380, 416'd0, 64'd24});
        1: check("empty_block", cap_blk[base % 64], {8'h80, 504'd0});
        3: check("b64_len_block", cap_blk[(base + 1) % 64], {8'h80, 440'd0, 64'h200});
        4: check("b55_tail", 512'(cap_blk[base % 64][71:0]), 512'({8'h80, 64'd440}));
        5: begin
          check("b63_pad", 512'(cap_blk[base % 64][7:0]), 512'h80);
          check("b63_len_block", cap_blk[(base + 1) % 64], {448'd0, 64'd504});
        end
        default: ;
      endcase
      @(negedge clk);
      check($sformatf("v%0d_pulse", i), 512'(digest_valid), 512'd0);
      check($sformatf("v%0d_hold", i), 512'(digest), 512'(vt[i].exp));
    end

    // Back-to-back: feeder is ready the cycle after the final release.
    send_msg("abc", 1'b0, 0);
    wait_digest(ok);
    check("b2b_dv1", 512'(ok), 512'd1);
    @(negedge clk);
    check("b2b_ready", 512'(in_ready), 512'd1);
    check("b2b_busy", 512'(busy), 512'd0);
    base = nblk;
    send_msg("abc", 1'b0, 0);
    wait_digest(ok);
    check("b2b_digest", 512'(digest), 512'(D_ABC));
    check("b2b_first", 512'(cap_first[base % 64]), 512'd1);

    // keep=0 without last is consumed and ignored.
    send_beat(8'h61, 1'b1, 1'b0, 0);
    send_beat(8'hff, 1'b0, 1'b0, 0);
    send_beat(8'h62, 1'b1, 1'b0, 0);
    send_beat(8'h63, 1'b1, 1'b1, 0);
    wait_digest(ok);
    check("proto_digest", 512'(digest), 512'(D_ABC));

    // Reset while the core is working on the block.
    send_msg(s56, 1'b0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int w = 0; w < 200 && !(blk_start && !core_ready); w++) @(negedge clk);
    check("reached_wait", 512'(blk_start && !core_ready), 512'd1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 512'(in_ready), 512'd0);
    check("mid_rst_blk_start", 512'(blk_start), 512'd0);
    check("mid_rst_blk_first", 512'(blk_first), 512'd1);
    check("mid_rst_blk_data", blk_data, 512'd0);
    check("mid_rst_digest", 512'(digest), 512'd0);
    check("mid_rst_busy", 512'(busy), 512'd0);
    @(negedge clk);
    rst = 1'b0;
    send_msg("abc", 1'b0, 0);
    wait_digest(ok);
    check("post_rst_digest", 512'(digest), 512'(D_ABC));
    check("post_rst_nblk", 512'(nblk), 512'd1);

    check("in_ready_low_while_issued", 512'(viol), 512'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sha256_msg_feeder.md
# sha256_msg_feeder

Byte-stream front end for the SHA-256 compression core. Accepts a message one byte per cycle and performs FIPS 180-4 padding: 0x80 terminator, zero fill, and a 64-bit big-endian bit length. It drives the core's 512-bit block/start/first-run interface one block at a time and returns the final 256-bit digest with a one-cycle valid pulse.

## Interface
- No parameters.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input byte offered.
- in_ready  out  1  feeder accepts the byte this cycle; transfer occurs when in_valid & in_ready.
- in_data  in  8  message byte.
- in_keep  in  1  1 = in_data is a message byte. 0 is legal only with in_last=1 and means "end, no byte"; this is the encoding for an empty message.
- in_last  in  1  final beat of the message.
- blk_data  out  512  block to the core; byte 0 of the block is at [511:504].
- blk_start  out  1  start request to the core.
- blk_first  out  1  1 = first block of the message, so the core loads the IV.
- core_ready  in  1  core's ready output.
- core_hash  in  256  core's hash output.
- digest  out  256  final digest; holds its value until the next message completes.
- digest_valid  out  1  one-cycle pulse when digest updates.
- busy  out  1  a message is in progress (any state other than FILL with byte count 0 and no pending block).

## Operation
- Registers:
  - blk_data (512).
  - pos (7 bits, 0..64): byte index within the current block.
  - len (64 bits): bit count, incremented by 8 per accepted byte, wrapping mod 2^64.
  - first flag: set at reset and after each digest.
  - pend_len flag: a length-only block is still owed.
  - final flag: the block being issued is the last block of the message.
- States: FILL, ISSUE, WAIT, REL.
- FILL: in_ready=1.
  - On an accepted beat with in_keep=1: blk_data byte[pos] <= in_data, pos++, len += 8.
  - When pos reaches 64 and in_last=0: go to ISSUE with final=0.
- Last beat handling uses k = pos after the last byte is written, with len including that byte.
  - k ≤ 55: byte[k] <= 0x80; bytes 56..63 <= len; final=1; go to ISSUE.
  - 56 ≤ k ≤ 63: byte[k] <= 0x80; pend_len=1; final=0; go to ISSUE.
  - k = 64: pend_len=1 and a pad-0x80 flag is set; final=0; go to ISSUE.
- ISSUE: blk_start=1. Wait for core_ready=0, which is the core's acknowledgement and clears any stale ready from the previous block. Then go to WAIT.
- WAIT: blk_start=1. When core_ready=1:
  - If final: digest <= core_hash and digest_valid <= 1.
  - Go to REL.
- REL: blk_start=0 for exactly one cycle so the core returns to idle.
  - blk_data <= 0 and pos <= 0.
  - blk_first <= 0, or blk_first <= 1 if the message just completed.
  - If pend_len: build the next block in place, with byte 0 = 0x80 when the pad-0x80 flag is set and bytes 56..63 = len. Clear pend_len, set final=1, go to ISSUE.
  - Otherwise: go to FILL, and clear len if final.
- blk_data and blk_first are stable from ISSUE entry until REL.
- in_ready=0 in ISSUE, WAIT and REL; there is no double buffering.
- Reset values:
  - in_ready=0 during reset, 1 after (FILL).
  - blk_data=0, blk_start=0, blk_first=1.
  - digest=0, digest_valid=0, busy=0.
  - len=0, pos=0, all flags 0 except first.
- Reset mid-operation aborts the message with no digest. The core shares rst and is reset with the feeder.
- in_keep=0 with in_last=0 is a protocol error: the beat is consumed and ignored.

## Timing
- FILL accepts one byte per cycle with no bubbles until the block is full or the last beat arrives.
- ISSUE is entered the cycle after the 64th or last byte is accepted.
- ISSUE→WAIT takes 1 cycle, because the core clears ready on the edge at which it samples start.
- WAIT lasts for the core latency, about 66 cycles.
- REL lasts 1 cycle.
- Single-block message: digest_valid fires about 69 cycles after the last beat.
- digest and digest_valid become visible together in the REL cycle of the final block.
- A new message may start the cycle after REL of the previous message's final block.

## Test plan
- "abc" (3 beats, last on 'c') -> 1 block, bytes 56..63 = 0x18. digest = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Empty message (single beat, in_keep=0, in_last=1) -> 1 block = 0x80 followed by zeros. digest = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- 56-byte "abcdbcdecdefdefg...nopq" -> 2 blocks, blk_first=1 then 0. digest = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- 64-byte message -> 2 blocks, second block byte 0 = 0x80 and length = 0x200. Compare against the reference model.
- Throttled in_valid (random gaps) and back-to-back messages -> identical digests; in_ready=0 throughout ISSUE/WAIT/REL; blk_first=1 on the first block of each message.
- rst asserted in WAIT -> all outputs at reset values immediately. The next "abc" then produces the correct digest.
